sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO built around an internal simple-dual-port register array (one write port, one registered read port).
- Generalises the fixed 8-bit dual-port memory:
  - parametrised data width and depth;
  - pointer management, occupancy count and full/empty/threshold flags;
  - sticky overflow/underflow error reporting.
- Used as the same-clock buffer stage ahead of the async FIFO and as a general elastic buffer between pipeline stages.

---
 rtl/sync_fifo_param.sv | 132 +++++++++++++
 tb/tb_sync_fifo_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO around a simple-dual-port register array with registered read.
// Provides occupancy count, full/empty/threshold flags and sticky overflow/underflow.
module sync_fifo_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   AF_CNT    = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0]   AE_CNT    = (ADDR_W + 1)'(AE_LEVEL);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [ADDR_W:0]   count_reg, count_next;
   logic [DATA_W-1:0] rd_data_reg;
   logic              rd_valid_reg;
   logic              overflow_reg, overflow_next;
   logic              underflow_reg, underflow_next;

   logic full_int, empty_int;
   logic wr_acc, rd_acc;

   // Flags come straight from the registered count, so they track the post-edge state.
   assign full_int  = (count_reg == DEPTH_CNT);
   assign empty_int = (count_reg == '0);
   assign wr_acc    = wr_en & ~full_int;
   assign rd_acc    = rd_en & ~empty_int;

   always_comb begin
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      count_next     = count_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;

      if (wr_acc) begin
         wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      if (rd_acc) begin
         rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end

      unique case ({wr_acc, rd_acc})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase

      // A fresh error on the same edge as clr_err keeps the flag set.
      if (clr_err) begin
         overflow_next  = 1'b0;
         underflow_next = 1'b0;
      end
      if (wr_en & full_int) begin
         overflow_next = 1'b1;
      end
      if (rd_en & empty_int) begin
         underflow_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   // Array write port; contents survive reset, but a write during reset is discarded.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Registered read port; rd_data holds its value between pops.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_acc;
         if (rd_acc) begin
            rd_data_reg <= mem[rd_ptr_reg];
         end
      end
   end

   assign rd_data      = rd_data_reg;
   assign rd_valid     = rd_valid_reg;
   assign full         = full_int;
   assign empty        = empty_int;
   assign almost_full  = (count_reg >= AF_CNT);
   assign almost_empty = (count_reg <= AE_CNT);
   assign count        = count_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the FIFO's externally visible behaviour.
module tb_sync_fifo_param;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 4;
   localparam int DEPTH    = 2 ** ADDR_W;
   localparam int AF_LEVEL = 14;
   localparam int AE_LEVEL = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;
   logic              clr_err;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int cyc       = 0;

   // Reference model state
   logic [DATA_W-1:0] m_q[$];
   logic [DATA_W-1:0] m_rd_data;
   bit                m_rd_valid;
   bit                m_ov;
   bit                m_un;

   sync_fifo_param #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .AF_LEVEL(AF_LEVEL),
      .AE_LEVEL(AE_LEVEL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow),
      .clr_err     (clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, then compare every output after the edge.
   task automatic cycle(input bit r, input bit w, input logic [DATA_W-1:0] d,
                        input bit rd, input bit c);
      bit m_full, m_empty;
      rst     = r;
      wr_en   = w;
      wr_data = d;
      rd_en   = rd;
      clr_err = c;

      m_full  = (m_q.size() == DEPTH);
      m_empty = (m_q.size() == 0);
      if (r) begin
         m_q.delete();
         m_rd_data  = '0;
         m_rd_valid = 1'b0;
         m_ov       = 1'b0;
         m_un       = 1'b0;
      end else begin
         m_rd_valid = rd && !m_empty;
         if (rd && !m_empty) m_rd_data = m_q.pop_front();
         if (w && !m_full) m_q.push_back(d);
         if (c) begin
            m_ov = 1'b0;
            m_un = 1'b0;
         end
         if (w && m_full) m_ov = 1'b1;
         if (rd && m_empty) m_un = 1'b1;
      end

      @(posedge clk);
      #1;
      cyc++;
      check("count", 32'(count), 32'(m_q.size()));
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("full", 32'(full), 32'(m_q.size() == DEPTH));
      check("almost_full", 32'(almost_full), 32'(m_q.size() >= AF_LEVEL));
      check("almost_empty", 32'(almost_empty), 32'(m_q.size() <= AE_LEVEL));
      check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      check("rd_data", 32'(rd_data), 32'(m_rd_data));
      check("overflow", 32'(overflow), 32'(m_ov));
      check("underflow", 32'(underflow), 32'(m_un));
      $display("cyc=%0d rst=%0b wr=%0b wd=%02h rd=%0b clr=%0b | cnt=%0d rv=%0b rdd=%02h ov=%0b un=%0b",
               cyc, r, w, d, rd, c, count, rd_valid, rd_data, overflow, underflow);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [DATA_W-1:0] d);
      cycle(1'b0, 1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic pop();
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL >= 1 && AF_LEVEL <= DEPTH && AE_LEVEL >= 0)) begin
         $display("FAIL params AE_LEVEL=%0d AF_LEVEL=%0d not legal", AE_LEVEL, AF_LEVEL);
         $fatal(1);
      end

      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ov       = 1'b0;
      m_un       = 1'b0;

      // Reset then idle
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) idle();

      // Fill and drain in order
      for (int i = 0; i < DEPTH; i++) push(8'(i));
      for (int i = 0; i < DEPTH; i++) pop();
      idle();

      // Overflow at full, underflow at empty, then clear
      for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i));
      push(8'hAA);
      idle();
      for (int i = 0; i < DEPTH; i++) pop();
      pop();
      idle();
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Simultaneous read/write at count 5, pointers wrap
      for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      for (int i = 0; i < DEPTH - 5; i++) push(8'(8'hC0 + i));
      cycle(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) pop();
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Both requested at empty, then read the word back
      cycle(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
      pop();
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Error while clr_err is asserted keeps the flag set
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Mid-operation reset with a concurrent write
      for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
      pop();
      push(8'h29);
      cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
      push(8'h5A);
      pop();
      idle();

      // Random traffic with alternating write/read bias to reach both ends
      for (int i = 0; i < 400; i++) begin
         int  wp;
         bit  w, rd, c, r;
         wp = ((i / 50) % 2 == 0) ? 75 : 25;
         w  = ($urandom_range(0, 99) < wp);
         rd = ($urandom_range(0, 99) < (100 - wp));
         c  = ($urandom_range(0, 19) == 0);
         r  = ($urandom_range(0, 149) == 0);
         cycle(r, w, 8'($urandom), rd, c);
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
